// File: rtl/ov_fifo_pkg.sv
// Shared types and sizing helpers for the OV7670 frame-FIFO readout controller.
package ov_fifo_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        WRST,
        CAPTURE,
        RRST,
        RD_LO,
        RD_HI,
        WAIT_ACK,
        DONE
    } state_t;

    localparam int DEF_IMG_W = 320;
    localparam int DEF_IMG_H = 240;
    localparam int DEF_BPP   = 2;
    localparam int DEF_FRAME_BYTES = DEF_IMG_W * DEF_IMG_H * DEF_BPP;

    // Read-pointer reset spans two full read-clock periods.
    localparam int RRST_CYC = 4;

    function automatic int frame_bytes(input int w, input int h, input int bpp);
        return w * h * bpp;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ov_fifo_reader_vsync_catch.sv
// Catches short asynchronous VSYNC pulses with a toggle flop and turns each one
// into a single-cycle SYS_CLK pulse.
module vsync_catch (
    input  logic SYS_CLK,
    input  logic RST_N,
    input  logic OV_vsync,
    output logic vs_rise
);

    logic       vs_toggle;
    logic [1:0] vs_sync;
    logic       vs_sync_d;

    // Toggle survives pulses narrower than a SYS_CLK period.
    always_ff @(posedge OV_vsync or negedge RST_N) begin
        if (!RST_N) begin
            vs_toggle <= 1'b0;
        end else begin
            vs_toggle <= ~vs_toggle;
        end
    end

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            vs_sync   <= 2'b00;
            vs_sync_d <= 1'b0;
        end else begin
            vs_sync   <= {vs_sync[0], vs_toggle};
            vs_sync_d <= vs_sync[1];
        end
    end

    assign vs_rise = vs_sync[1] ^ vs_sync_d;

endmodule

// File: rtl/ov_fifo_reader.sv
// Brackets one camera frame into the AL422B FIFO on VSYNC, then drains it byte by
// byte with a self-generated read clock into the UART over valid/ready.
module ov_fifo_reader
    import ov_fifo_pkg::*;
#(
    parameter int IMG_W    = DEF_IMG_W,
    parameter int IMG_H    = DEF_IMG_H,
    parameter int BPP      = DEF_BPP,
    parameter int WRST_CYC = 4
) (
    input  logic       SYS_CLK,
    input  logic       RST_N,
    input  logic       cfg_done,
    input  logic       OV_vsync,
    input  logic [7:0] OV_data,
    output logic       OV_wrst,
    output logic       OV_wen,
    output logic       OV_rrst,
    output logic       OV_oe,
    output logic       OV_rclk,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       frame_done
);

    localparam int FRAME_BYTES = frame_bytes(IMG_W, IMG_H, BPP);
    localparam int CNT_W       = cnt_width(FRAME_BYTES);
    localparam int PH_MAX      = (WRST_CYC > RRST_CYC) ? WRST_CYC : RRST_CYC;
    localparam int PH_W        = cnt_width(PH_MAX);

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(FRAME_BYTES - 1);
    localparam logic [PH_W-1:0]  WRST_LAST = PH_W'(WRST_CYC - 1);
    localparam logic [PH_W-1:0]  RRST_LAST = PH_W'(RRST_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] byte_cnt;
    logic [PH_W-1:0]  phase_cnt;
    logic             vs_rise;

    vsync_catch u_vsync_catch (
        .SYS_CLK  (SYS_CLK),
        .RST_N    (RST_N),
        .OV_vsync (OV_vsync),
        .vs_rise  (vs_rise)
    );

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            byte_cnt   <= '0;
            phase_cnt  <= '0;
            OV_wrst    <= 1'b1;
            OV_wen     <= 1'b0;
            OV_rrst    <= 1'b1;
            OV_oe      <= 1'b1;
            OV_rclk    <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_done) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (vs_rise) begin
                        OV_wrst   <= 1'b0;
                        OV_wen    <= 1'b1;
                        phase_cnt <= '0;
                        state     <= WRST;
                    end
                end
                WRST: begin
                    if (phase_cnt == WRST_LAST) begin
                        OV_wrst <= 1'b1;
                        state   <= CAPTURE;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                CAPTURE: begin
                    if (vs_rise) begin
                        OV_wen    <= 1'b0;
                        OV_rrst   <= 1'b0;
                        OV_oe     <= 1'b0;
                        phase_cnt <= '0;
                        state     <= RRST;
                    end
                end
                // Two read-clock periods with the read pointer held in reset, ending low.
                RRST: begin
                    OV_rclk <= ~OV_rclk;
                    if (phase_cnt == RRST_LAST) begin
                        OV_rrst <= 1'b1;
                        state   <= RD_LO;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end
                RD_LO: begin
                    state <= RD_HI;
                end
                RD_HI: begin
                    tx_data  <= OV_data;
                    tx_valid <= 1'b1;
                    OV_rclk  <= 1'b1;
                    state    <= WAIT_ACK;
                end
                // The read-clock fall after the transfer advances the FIFO to the next byte.
                WAIT_ACK: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        OV_rclk  <= 1'b0;
                        if (byte_cnt == LAST_BYTE) begin
                            state <= DONE;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                            state    <= RD_LO;
                        end
                    end
                end
                DONE: begin
                    frame_done <= 1'b1;
                    OV_oe      <= 1'b1;
                    byte_cnt   <= '0;
                    state      <= cfg_done ? ARM : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov_fifo_reader.sv
// Directed bench for ov_fifo_reader: 4x2 RGB565 frames (16 bytes) against a
// behavioural AL422B read-side model.
module tb_ov_fifo_reader;

    logic       SYS_CLK = 1'b0;
    logic       RST_N;
    logic       cfg_done;
    logic       OV_vsync;
    logic [7:0] OV_data;
    logic       OV_wrst;
    logic       OV_wen;
    logic       OV_rrst;
    logic       OV_oe;
    logic       OV_rclk;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       frame_done;

    logic [14:0] out_vec;
    localparam logic [14:0] RESET_VEC = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    int n_checks = 0;
    int n_fail   = 0;

    int   byte_q[$];
    int   stamp_q[$];
    int   done_pulses;
    int   hold_bad;
    int   ctrl_bad;
    bit   timed_out;
    logic oe_at_done;

    logic [7:0] fifo_q;
    logic       rclk_prev;
    logic       rrst_prev;

    ov_fifo_reader #(
        .IMG_W    (4),
        .IMG_H    (2),
        .BPP      (2),
        .WRST_CYC (4)
    ) dut (
        .SYS_CLK    (SYS_CLK),
        .RST_N      (RST_N),
        .cfg_done   (cfg_done),
        .OV_vsync   (OV_vsync),
        .OV_data    (OV_data),
        .OV_wrst    (OV_wrst),
        .OV_wen     (OV_wen),
        .OV_rrst    (OV_rrst),
        .OV_oe      (OV_oe),
        .OV_rclk    (OV_rclk),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .frame_done (frame_done)
    );

    always #25 SYS_CLK = ~SYS_CLK;

    assign out_vec = {OV_wrst, OV_wen, OV_rrst, OV_oe, OV_rclk, tx_data, tx_valid, frame_done};
    assign OV_data = fifo_q;

    // FIFO read side: pointer reset on RRST fall, next byte on every RCLK fall.
    initial begin
        fifo_q    = 8'd0;
        rclk_prev = 1'b0;
        rrst_prev = 1'b1;
        forever begin
            @(OV_rclk or OV_rrst);
            if (rclk_prev === 1'b1 && OV_rclk === 1'b0) fifo_q = fifo_q + 8'd1;
            if (rrst_prev === 1'b1 && OV_rrst === 1'b0) fifo_q = 8'd0;
            rclk_prev = OV_rclk;
            rrst_prev = OV_rrst;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_vsync();
        #5 OV_vsync = 1'b1;
        #40 OV_vsync = 1'b0;
    endtask

    task automatic arm_frame(output bit ok);
        bit low_seen;
        ok = 1'b0;
        low_seen = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        pulse_vsync();
        repeat (12) @(negedge SYS_CLK);
        pulse_vsync();
        for (int k = 0; k < 40; k++) begin
            @(negedge SYS_CLK);
            if (OV_rrst === 1'b0) low_seen = 1'b1;
            else if (low_seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Collects one frame of readout; all judging is done by the calling test.
    task automatic read_frame(input int stall_at, input int stall_len, input int vs_at,
                              input int rst_at, input int drop_cfg_at);
        int cyc;
        int tail;
        bit seen_done;
        logic [7:0] held;
        byte_q.delete();
        stamp_q.delete();
        done_pulses = 0;
        hold_bad    = 0;
        ctrl_bad    = 0;
        timed_out   = 1'b1;
        oe_at_done  = 1'b0;
        seen_done   = 1'b0;
        tail        = 0;
        tx_ready    = 1'b1;
        for (cyc = 0; cyc < 1000; cyc++) begin
            @(negedge SYS_CLK);
            if (frame_done === 1'b1) begin
                done_pulses++;
                oe_at_done = OV_oe;
                seen_done  = 1'b1;
            end
            if (seen_done) begin
                tail++;
                if (tail > 3) begin
                    timed_out = 1'b0;
                    break;
                end
                continue;
            end
            if (OV_rrst !== 1'b1 || OV_wen !== 1'b0 || OV_wrst !== 1'b1) ctrl_bad++;
            if (tx_valid === 1'b1) begin
                if (byte_q.size() == rst_at) begin
                    #10 RST_N = 1'b0;
                    #1;
                    timed_out = 1'b0;
                    return;
                end
                if (byte_q.size() == vs_at || byte_q.size() == vs_at + 5) begin
                    fork
                        pulse_vsync();
                    join_none
                end
                if (byte_q.size() == drop_cfg_at) cfg_done = 1'b0;
                if (byte_q.size() == stall_at) begin
                    held = tx_data;
                    tx_ready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge SYS_CLK);
                        cyc++;
                        if (!(tx_valid === 1'b1 && OV_rclk === 1'b1 && tx_data === held)) hold_bad++;
                    end
                    tx_ready = 1'b1;
                end
                byte_q.push_back(int'(tx_data));
                stamp_q.push_back(cyc);
            end
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        n_checks++;
        if (out_vec !== RESET_VEC) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %b want %b", out_vec, RESET_VEC);
        end
        RST_N = 1'b1;
    endtask

    task automatic test_capture();
        int lat;
        int low_n;
        int hi_n;
        cfg_done = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        n_checks++;
        if (OV_wrst !== 1'b1 || OV_wen !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL arm_quiet: got wrst=%b wen=%b want wrst=1 wen=0", OV_wrst, OV_wen);
        end
        pulse_vsync();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SYS_CLK);
            if (OV_wrst === 1'b0) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("[TB] FAIL wrst_latency: got %0d want 3", lat);
        end
        n_checks++;
        if (OV_wen !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL wen_with_wrst: got %b want 1", OV_wen);
        end
        low_n = 0;
        for (int k = 0; k < 20 && OV_wrst === 1'b0; k++) begin
            low_n++;
            @(negedge SYS_CLK);
        end
        n_checks++;
        if (low_n != 4) begin
            n_fail++;
            $display("[TB] FAIL wrst_low_cycles: got %0d want 4", low_n);
        end
        repeat (5) @(negedge SYS_CLK);
        n_checks++;
        if (OV_wen !== 1'b1 || OV_wrst !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL capture_window: got wen=%b wrst=%b want wen=1 wrst=1", OV_wen, OV_wrst);
        end
        pulse_vsync();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SYS_CLK);
            if (OV_rrst === 1'b0) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 3 || OV_wen !== 1'b0 || OV_oe !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rrst_start: got lat=%0d wen=%b oe=%b want lat=3 wen=0 oe=0", lat, OV_wen, OV_oe);
        end
        low_n = 0;
        hi_n  = 0;
        for (int k = 0; k < 20 && OV_rrst === 1'b0; k++) begin
            low_n++;
            if (OV_rclk === 1'b1) hi_n++;
            @(negedge SYS_CLK);
        end
        n_checks++;
        if (low_n != 4 || hi_n != 2) begin
            n_fail++;
            $display("[TB] FAIL rrst_pulse: got low=%0d rclk_hi=%0d want low=4 rclk_hi=2", low_n, hi_n);
        end
        n_checks++;
        if (OV_rclk !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rrst_end_rclk: got %b want 0", OV_rclk);
        end
    endtask

    task automatic test_stream();
        read_frame(-1, 0, -1, -1, -1);
        n_checks++;
        if (timed_out || byte_q.size() != 16) begin
            n_fail++;
            $display("[TB] FAIL stream_count: got %0d bytes timeout=%0d want 16 timeout=0", byte_q.size(), timed_out);
        end
        for (int i = 0; i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] != i + 2) begin
                n_fail++;
                $display("[TB] FAIL stream_data[%0d]: got %0d want %0d", i, byte_q[i], i + 2);
            end
            if (i > 0) begin
                n_checks++;
                if (stamp_q[i] - stamp_q[i-1] != 3) begin
                    n_fail++;
                    $display("[TB] FAIL stream_spacing[%0d]: got %0d want 3", i, stamp_q[i] - stamp_q[i-1]);
                end
            end
        end
        n_checks++;
        if (done_pulses != 1 || oe_at_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL stream_done: got pulses=%0d oe=%b want pulses=1 oe=1", done_pulses, oe_at_done);
        end
        n_checks++;
        if (ctrl_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL stream_ctrl: got %0d bad cycles want 0", ctrl_bad);
        end
    endtask

    task automatic test_stall();
        bit ok;
        arm_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL stall_arm: got %0d want 1", ok);
        end
        read_frame(5, 20, -1, -1, -1);
        n_checks++;
        if (timed_out || byte_q.size() != 16 || done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL stall_count: got %0d bytes pulses=%0d want 16 pulses=1", byte_q.size(), done_pulses);
        end
        n_checks++;
        if (hold_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL stall_hold: got %0d unstable cycles want 0", hold_bad);
        end
        for (int i = 0; i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] != i + 2) begin
                n_fail++;
                $display("[TB] FAIL stall_data[%0d]: got %0d want %0d", i, byte_q[i], i + 2);
            end
        end
    endtask

    task automatic test_extra_vsync();
        bit ok;
        arm_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL xvs_arm: got %0d want 1", ok);
        end
        read_frame(-1, 0, 2, -1, -1);
        n_checks++;
        if (timed_out || byte_q.size() != 16 || done_pulses != 1 || ctrl_bad != 0) begin
            n_fail++;
            $display("[TB] FAIL xvs_frame: got bytes=%0d pulses=%0d ctrl_bad=%0d want 16 1 0",
                     byte_q.size(), done_pulses, ctrl_bad);
        end
        for (int i = 0; i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] != i + 2) begin
                n_fail++;
                $display("[TB] FAIL xvs_data[%0d]: got %0d want %0d", i, byte_q[i], i + 2);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        arm_frame(ok);
        read_frame(-1, 0, -1, 9, -1);
        n_checks++;
        if (timed_out || byte_q.size() != 9) begin
            n_fail++;
            $display("[TB] FAIL midrst_reach: got %0d bytes want 9", byte_q.size());
        end
        n_checks++;
        if (out_vec !== RESET_VEC) begin
            n_fail++;
            $display("[TB] FAIL midrst_async: got %b want %b", out_vec, RESET_VEC);
        end
        @(negedge SYS_CLK);
        RST_N = 1'b1;
        arm_frame(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL midrst_rearm: got %0d want 1", ok);
        end
        read_frame(-1, 0, -1, -1, -1);
        n_checks++;
        if (timed_out || byte_q.size() != 16 || done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL midrst_frame: got %0d bytes pulses=%0d want 16 pulses=1", byte_q.size(), done_pulses);
        end
        for (int i = 0; i < byte_q.size(); i++) begin
            n_checks++;
            if (byte_q[i] != i + 2) begin
                n_fail++;
                $display("[TB] FAIL midrst_data[%0d]: got %0d want %0d", i, byte_q[i], i + 2);
            end
        end
    endtask

    task automatic test_cfg_idle();
        bit ok;
        int wrst_low;
        int lat;
        arm_frame(ok);
        read_frame(-1, 0, -1, -1, 10);
        n_checks++;
        if (timed_out || byte_q.size() != 16 || done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL idle_frame: got %0d bytes pulses=%0d want 16 pulses=1", byte_q.size(), done_pulses);
        end
        wrst_low = 0;
        repeat (3) @(negedge SYS_CLK);
        for (int p = 0; p < 2; p++) begin
            pulse_vsync();
            for (int k = 0; k < 12; k++) begin
                @(negedge SYS_CLK);
                if (OV_wrst !== 1'b1 || OV_wen !== 1'b0) wrst_low++;
            end
        end
        n_checks++;
        if (wrst_low != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_ignores_vsync: got %0d active cycles want 0", wrst_low);
        end
        cfg_done = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        pulse_vsync();
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge SYS_CLK);
            if (OV_wrst === 1'b0) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 3) begin
            n_fail++;
            $display("[TB] FAIL idle_rearm_wrst: got latency %0d want 3", lat);
        end
    endtask

    initial begin
        RST_N    = 1'b0;
        cfg_done = 1'b0;
        OV_vsync = 1'b0;
        tx_ready = 1'b1;
        test_reset();
        test_capture();
        test_stream();
        test_stall();
        test_extra_vsync();
        test_reset_midframe();
        test_cfg_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
